// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares the single external SRAM port between the coefficient fetch unit
//   (reads) and the sample store unit (writes). Ownership is granted in
//   bounded bursts, round-robin. Every change of owner costs one idle
//   turnaround cycle. Read data is returned with a valid strobe that is
//   aligned to the fixed SRAM read latency.
//
//   Requester handshake (both ports): the requester raises *_req and holds
//   its address (and write data) stable while *_req is high. The access is
//   accepted at the rising edge where *_gnt is high. *_gnt is combinational
//   from the current state and *_req. Read data comes back without
//   backpressure: fetch_rvalid pulses once per accepted read, in order.
//
// Ports
//   Clock, Reset        : system clock; synchronous active-high reset
//   fetch_req/addr/gnt  : read request, 18-bit address, accept strobe
//   fetch_rvalid/rdata  : read data return (rdata passes SRAM_read_data through)
//   store_req/addr/wdata/gnt : write request, address, data, accept strobe
//   SRAM_address, SRAM_write_data, SRAM_we_n : registered SRAM port
//   SRAM_read_data      : data from the SRAM
//   stat_fetch_cnt, stat_stall_cnt : statistics counters; these are
//                         populated only when SRAM_ARB_STATS_EN is defined
//                         and are tied to zero otherwise
//
// Parameters
//   READ_LATENCY : cycles from an SRAM_address update to valid SRAM_read_data (>= 1)
//   MAX_BURST    : maximum consecutive accesses per ownership

module sram_port_arbiter #(
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        fetch_req,
  input  logic [17:0] fetch_addr,
  output logic        fetch_gnt,
  output logic        fetch_rvalid,
  output logic [15:0] fetch_rdata,
  input  logic        store_req,
  input  logic [17:0] store_addr,
  input  logic [15:0] store_wdata,
  output logic        store_gnt,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic [31:0] stat_fetch_cnt,
  output logic [31:0] stat_stall_cnt
);

  localparam int               CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_STORE = 2'd2,
    SWITCH    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             next_owner_q, next_owner_d;  // 1 = store, 0 = fetch
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [17:0] sram_address_q;
  logic [15:0] sram_write_data_q;
  logic        sram_we_n_q;

  // Bit 0 is set for the cycle in which SRAM_address carries the read
  // address. Bit i means that address was presented i cycles earlier, so bit
  // READ_LATENCY lines up with the cycle where SRAM_read_data is valid.
  logic [READ_LATENCY:0] rd_pipe_q;

  logic own_req, other_req, end_burst;

  assign fetch_gnt = (state_q == OWN_FETCH) & fetch_req;
  assign store_gnt = (state_q == OWN_STORE) & store_req;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      next_owner_q <= 1'b0;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      next_owner_q <= next_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    next_owner_d = next_owner_q;
    burst_cnt_d  = burst_cnt_q;
    own_req      = 1'b0;
    other_req    = 1'b0;
    end_burst    = 1'b0;
    unique case (state_q)
      IDLE: begin
        burst_cnt_d = '0;
        // Store wins a tie so decoded samples drain first.
        if (store_req)      state_d = OWN_STORE;
        else if (fetch_req) state_d = OWN_FETCH;
      end
      OWN_FETCH, OWN_STORE: begin
        own_req   = (state_q == OWN_FETCH) ? fetch_req : store_req;
        other_req = (state_q == OWN_FETCH) ? store_req : fetch_req;
        // A dropped request on a grant cycle issues nothing and ends the burst.
        end_burst = ~own_req | (burst_cnt_q == LAST_BEAT);
        if (own_req) burst_cnt_d = burst_cnt_q + CNT_W'(1);
        if (end_burst) begin
          burst_cnt_d = '0;
          if (other_req) begin
            state_d      = SWITCH;
            next_owner_d = (state_q == OWN_FETCH);
          end else if (!own_req) begin
            state_d = IDLE;
          end
          // Otherwise the limit was hit with nobody waiting: keep ownership
          // and start a fresh burst without a bubble.
        end
      end
      SWITCH: begin
        // One idle cycle so the bus can turn around between read and write.
        state_d = next_owner_q ? OWN_STORE : OWN_FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------- SRAM port
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sram_address_q    <= '0;
      sram_write_data_q <= '0;
      sram_we_n_q       <= 1'b1;
    end else begin
      sram_we_n_q <= 1'b1;
      if (fetch_gnt) begin
        sram_address_q <= fetch_addr;
      end else if (store_gnt) begin
        sram_address_q    <= store_addr;
        sram_write_data_q <= store_wdata;
        sram_we_n_q       <= 1'b0;
      end
    end
  end

  assign SRAM_address    = sram_address_q;
  assign SRAM_write_data = sram_write_data_q;
  assign SRAM_we_n       = sram_we_n_q;

  // -------------------------------------------------------- read return
  always_ff @(posedge Clock) begin
    if (Reset) rd_pipe_q <= '0;
    else       rd_pipe_q <= {rd_pipe_q[READ_LATENCY-1:0], fetch_gnt};
  end

  assign fetch_rvalid = rd_pipe_q[READ_LATENCY];
  assign fetch_rdata  = SRAM_read_data;

  // --------------------------------------------------------- statistics
`ifdef SRAM_ARB_STATS_EN
  logic [31:0] stat_fetch_cnt_q, stat_stall_cnt_q;
  logic        stall;

  assign stall = (fetch_req & ~fetch_gnt) | (store_req & ~store_gnt);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stat_fetch_cnt_q <= '0;
      stat_stall_cnt_q <= '0;
    end else begin
      if (fetch_gnt) stat_fetch_cnt_q <= stat_fetch_cnt_q + 32'd1;
      if (stall)     stat_stall_cnt_q <= stat_stall_cnt_q + 32'd1;
    end
  end

  assign stat_fetch_cnt = stat_fetch_cnt_q;
  assign stat_stall_cnt = stat_stall_cnt_q;
`else
  assign stat_fetch_cnt = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter. A reference model of the ownership rules
// predicts the grants, the SRAM bus contents and the statistics in every
// cycle. Each expected read datum goes into a queue when its read is
// accepted. A monitor pops an entry from that queue whenever fetch_rvalid
// is high.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
  localparam int READ_LATENCY = 2;
  localparam int MAX_BURST    = 8;

  // ---------------------------------------------------- clock and reset
  logic        Clock = 1'b0;
  logic        Reset;
  logic        fetch_req, store_req;
  logic [17:0] fetch_addr, store_addr;
  logic [15:0] store_wdata;
  logic        fetch_gnt, store_gnt, fetch_rvalid;
  logic [15:0] fetch_rdata;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic [31:0] stat_fetch_cnt, stat_stall_cnt;

  always #5 Clock = ~Clock;

  sram_port_arbiter #(.READ_LATENCY(READ_LATENCY), .MAX_BURST(MAX_BURST)) dut (
    .Clock(Clock), .Reset(Reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .store_req(store_req), .store_addr(store_addr), .store_wdata(store_wdata),
    .store_gnt(store_gnt),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data),
    .stat_fetch_cnt(stat_fetch_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  // SRAM content in the fetch region is a fixed function of the address.
  // Store addresses stay below 76800, so writes never alias the reads.
  function automatic logic [15:0] sram_fn(input logic [17:0] a);
    return a[15:0] ^ 16'h5A3C ^ {a[7:0], a[17:10]};
  endfunction

  // SRAM: data for the address presented in cycle k is valid in cycle k+2.
  logic [15:0] sram_d1, sram_d2;
  always @(posedge Clock) begin
    sram_d1 <= sram_fn(SRAM_address);
    sram_d2 <= sram_d1;
  end
  assign SRAM_read_data = sram_d2;

  // ---------------------------------------------------------- scoreboard
  int vectors = 0, miscompares = 0, cyc = 0;
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model of ownership: who may be granted in this cycle, and how
  // many accesses the current owner has used.
  localparam int M_NONE = 0, M_F = 1, M_S = 2, M_TO_F = 3, M_TO_S = 4;
  int          m_own = M_NONE, m_used = 0;
  logic [17:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_we_n;
  int          m_fcnt = 0, m_scnt = 0;
  bit          started = 0;
  logic        efg, esg, own, other, done;

  // Observations used by the driver and the directed checks.
  logic fg_seen = 1'b0, sg_seen = 1'b0;
  int   f_gnt_total = 0, s_gnt_total = 0, rv_total = 0, f_wait = 0, f_gnt_since_rst = 0;

  always @(negedge Clock) begin
    cyc++;
    // Read return: pop the queue whenever the DUT presents data.
    if (fetch_rvalid) begin
      rv_total++;
      if (exp_q.size() == 0) chk("rvalid_spurious", fetch_rvalid, 1'b0);
      else begin
        chk("rdata", fetch_rdata, exp_q.pop_front());
        chk("rvalid_cycle", cyc, exp_cyc_q.pop_front());
      end
    end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      chk("rvalid_missing", fetch_rvalid, 1'b1);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
    // Registered outputs reflect the decision made in the previous cycle.
    if (started) begin
      chk("sram_we_n", SRAM_we_n, m_we_n);
      chk("sram_address", SRAM_address, m_addr);
      chk("sram_write_data", SRAM_write_data, m_wdata);
`ifdef SRAM_ARB_STATS_EN
      chk("stat_fetch_cnt", stat_fetch_cnt, m_fcnt);
      chk("stat_stall_cnt", stat_stall_cnt, m_scnt);
`else
      chk("stat_fetch_cnt_off", stat_fetch_cnt, 0);
      chk("stat_stall_cnt_off", stat_stall_cnt, 0);
`endif
    end
    efg = (m_own == M_F) && fetch_req;
    esg = (m_own == M_S) && store_req;
    chk("fetch_gnt", fetch_gnt, efg);
    chk("store_gnt", store_gnt, esg);
    chk("gnt_exclusive", fetch_gnt & store_gnt, 1'b0);
    fg_seen = fetch_gnt;
    sg_seen = store_gnt;
    if (fetch_req && !fetch_gnt) f_wait++;
    if (Reset) begin
      m_own = M_NONE; m_used = 0;
      m_addr = '0; m_wdata = '0; m_we_n = 1'b1;
      m_fcnt = 0; m_scnt = 0; f_gnt_since_rst = 0;
      exp_q.delete(); exp_cyc_q.delete();
      started = 1;
    end else begin
      if (fetch_gnt) begin f_gnt_total++; f_gnt_since_rst++; end
      if (store_gnt) s_gnt_total++;
      m_we_n = 1'b1;
      if (efg) begin
        m_addr = fetch_addr;
        exp_q.push_back(sram_fn(fetch_addr));
        exp_cyc_q.push_back(cyc + READ_LATENCY + 1);
      end else if (esg) begin
        m_addr = store_addr; m_wdata = store_wdata; m_we_n = 1'b0;
      end
      if (efg) m_fcnt++;
      if ((fetch_req && !efg) || (store_req && !esg)) m_scnt++;
      case (m_own)
        M_NONE: if (store_req) m_own = M_S; else if (fetch_req) m_own = M_F;
        M_TO_F: m_own = M_F;
        M_TO_S: m_own = M_S;
        default: begin
          own   = (m_own == M_F) ? fetch_req : store_req;
          other = (m_own == M_F) ? store_req : fetch_req;
          done  = 1'b1;
          if (own) begin m_used++; done = (m_used == MAX_BURST); end
          if (done) begin
            m_used = 0;
            if (other)     m_own = (m_own == M_F) ? M_TO_S : M_TO_F;
            else if (!own) m_own = M_NONE;
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------- driver
  int          f_left = 0, s_left = 0;
  logic [17:0] f_addr = 18'd76800, s_addr = 18'd0;
  bit          rand_mode = 0;

  task automatic step();
    @(posedge Clock); #1;
    if (fg_seen) begin f_left--; f_addr++; end
    if (sg_seen) begin s_left--; s_addr++; store_wdata = 16'($urandom); end
    fetch_req  = (f_left > 0) && (!rand_mode || $urandom_range(0, 3) != 0);
    store_req  = (s_left > 0) && (!rand_mode || $urandom_range(0, 3) != 0);
    fetch_addr = f_addr;
    store_addr = s_addr;
  endtask

  int fb, sb, rb, wb;

  task automatic snap();
    fb = f_gnt_total; sb = s_gnt_total; rb = rv_total; wb = f_wait;
  endtask

  initial begin
    Reset = 1'b1; fetch_req = 1'b0; store_req = 1'b0;
    fetch_addr = '0; store_addr = '0; store_wdata = 16'h1234;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    @(negedge Clock);
    chk("rst_sram_address", SRAM_address, 18'd0);
    chk("rst_sram_we_n", SRAM_we_n, 1'b1);
    chk("rst_sram_wdata", SRAM_write_data, 16'd0);
    chk("rst_fetch_rvalid", fetch_rvalid, 1'b0);
    chk("rst_stat_fetch", stat_fetch_cnt, 32'd0);

    // Fetch-only, 16 reads: one wait cycle, then no bubble at the limit.
    snap(); f_addr = 18'd76800; f_left = 16;
    repeat (31) step();
    chk("s1_fetch_gnts", f_gnt_total - fb, 16);
    chk("s1_rvalids", rv_total - rb, 16);
    chk("s1_wait_cycles", f_wait - wb, 1);

    // Both requesting from IDLE: store first, alternating bursts of 8.
    snap(); f_addr = 18'd76800; f_left = 16; s_addr = 18'd0; s_left = 16;
    repeat (50) step();
    chk("s2_fetch_gnts", f_gnt_total - fb, 16);
    chk("s2_store_gnts", s_gnt_total - sb, 16);
    chk("s2_rvalids", rv_total - rb, 16);

    // Store arrives after 3 reads of a longer fetch burst.
    snap(); f_addr = 18'd77000; f_left = 12;
    for (int i = 0; i < 40 && (f_gnt_total - fb) < 3; i++) step();
    chk("s3_three_reads", (f_gnt_total - fb) >= 3, 1'b1);
    s_addr = 18'd1000; s_left = 4;
    repeat (40) step();
    chk("s3_fetch_gnts", f_gnt_total - fb, 12);
    chk("s3_store_gnts", s_gnt_total - sb, 4);

    // Fetch gives up after 5 accepts.
    snap(); f_addr = 18'd78000; f_left = 5;
    repeat (15) step();
    chk("s4_fetch_gnts", f_gnt_total - fb, 5);
    chk("s4_rvalids", rv_total - rb, 5);

    // Reset one cycle after a read accept: that read never returns.
    snap(); f_addr = 18'd79000; f_left = 3;
    for (int i = 0; i < 10; i++) begin
      step();
      if (f_gnt_total > fb) break;
    end
    chk("s5_read_accepted", f_gnt_total - fb, 1);
    Reset = 1'b1; f_left = 0; fetch_req = 1'b0;
    rb = rv_total;
    step();
    Reset = 1'b0;
    @(negedge Clock);
    chk("s5_sram_we_n", SRAM_we_n, 1'b1);
    chk("s5_sram_address", SRAM_address, 18'd0);
    chk("s5_fetch_gnt", fetch_gnt, 1'b0);
    repeat (6) step();
    chk("s5_no_rvalid", rv_total - rb, 0);

    // Random traffic with requesters that come and go.
    rand_mode = 1;
    for (int it = 0; it < 30; it++) begin
      if (f_left == 0 && $urandom_range(0, 1) == 1) begin
        f_addr = 18'(76800 + $urandom_range(0, 1000));
        f_left = $urandom_range(1, 20);
      end
      if (s_left == 0 && $urandom_range(0, 1) == 1) begin
        s_addr = 18'($urandom_range(0, 76000));
        s_left = $urandom_range(1, 20);
      end
      repeat (10) step();
    end
    rand_mode = 0; f_left = 0; s_left = 0;
    repeat (10) step();
    chk("rd_queue_drained", exp_q.size(), 0);
`ifdef SRAM_ARB_STATS_EN
    chk("final_stat_fetch", stat_fetch_cnt, f_gnt_since_rst);
    chk("final_stat_stall", stat_stall_cnt, m_scnt);
`else
    chk("final_stat_fetch_off", stat_fetch_cnt, 0);
    chk("final_stat_stall_off", stat_stall_cnt, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
